// File: rtl/seg7_pkg.sv
// ============================================================================
// Module      : seg7_pkg
// Description : Shared types and constants for the 7-segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

   typedef enum logic [0:0] {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } seg7_state_e;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Active-low patterns, seg[6]=a ... seg[0]=g; entry 15 listed first.
   localparam logic [15:0][6:0] HEX_TABLE = {
      7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
      7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
      7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
      7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return HEX_TABLE[nibble];
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational 4-bit nibble to active-low 7-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = hex_to_seg(nibble_i);
   end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module      : seg7_scan_ctrl
// Description : Time-multiplexed common-anode 7-segment driver with blank gap
//               between digits, blinking and tear-free frame shadowing.
//               Optional leading-zero blanking when SEG7_LZB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NDIG = 8
)
(
   input  logic              mclk,
   input  logic              clr,
   input  logic              scan_clk,
   input  logic              blink_clk,
   input  logic [4*NDIG-1:0] data,
   input  logic [NDIG-1:0]   dp,
   input  logic [NDIG-1:0]   blink_mask,
   output logic [NDIG-1:0]   an,
   output logic [6:0]        seg,
   output logic              dp_n,
   output logic              frame_start
);

   localparam int             IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0]  LAST_IDX = IW'(NDIG - 1);
   localparam logic [NDIG-1:0] ONE_DIG = {{(NDIG-1){1'b0}}, 1'b1};

   // Synchronisers
   logic [2:0]        scan_sync_q;
   logic [1:0]        blink_sync_q;
   logic              w_scan_tick;
   logic              w_blink_on;

   // Scan state
   seg7_state_e       state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              w_load;
   logic              blank0_q;

   // Frame shadow
   logic [4*NDIG-1:0] data_s_q;
   logic [NDIG-1:0]   dp_s_q;
   logic [NDIG-1:0]   blink_s_q;

   // Output registers
   logic [NDIG-1:0]   an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_n_q, dp_n_d;
   logic              frame_start_q, frame_start_d;

   logic [3:0]        w_nibble;
   logic [6:0]        w_hex;
   logic              w_blink_off;
   logic              w_lzb_off;

   assign w_scan_tick = scan_sync_q[1] & ~scan_sync_q[2];
   assign w_blink_on  = blink_sync_q[1];

   always_ff @(posedge mclk) begin
      if (clr) begin
         scan_sync_q  <= '0;
         blink_sync_q <= '0;
      end else begin
         scan_sync_q  <= {scan_sync_q[1:0], scan_clk};
         blink_sync_q <= {blink_sync_q[0], blink_clk};
      end
   end

   always_ff @(posedge mclk) begin
      if (clr) begin
         state_q   <= BLANK;
         idx_q     <= '0;
         blank0_q  <= 1'b0;
         data_s_q  <= '0;
         dp_s_q    <= '0;
         blink_s_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         blank0_q <= w_load;
         if (w_load) begin
            data_s_q  <= data;
            dp_s_q    <= dp;
            blink_s_q <= blink_mask;
         end
      end
   end

   // BLANK is a single-cycle anti-ghosting gap; the frame shadow is
   // captured in the gap that precedes digit 0.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      w_load  = 1'b0;
      case (state_q)
         BLANK: begin
            state_d = DRIVE;
            w_load  = (idx_q == '0);
         end
         DRIVE: begin
            if (w_scan_tick) begin
               state_d = BLANK;
               idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
         end
         default: state_d = BLANK;
      endcase
   end

   assign w_nibble = data_s_q[{idx_q, 2'b00} +: 4];

   seg7_hex_decode u_hex_decode (
      .nibble_i (w_nibble),
      .seg_o    (w_hex)
   );

   assign w_blink_off = ~w_blink_on & blink_s_q[idx_q];

`ifdef SEG7_LZB_EN
   logic [IW-1:0] w_msd;

   // Highest nonzero nibble; digit 0 stays lit even for an all-zero value.
   always_comb begin
      w_msd = '0;
      for (int k = 1; k < NDIG; k++) begin
         if (data_s_q[4*k +: 4] != 4'h0) w_msd = IW'(k);
      end
   end

   assign w_lzb_off = (idx_q > w_msd);
`else
   assign w_lzb_off = 1'b0;
`endif

   always_comb begin
      an_d          = '1;
      seg_d         = w_hex;
      dp_n_d        = ~dp_s_q[idx_q];
      frame_start_d = (state_q == DRIVE) && blank0_q;
      if (state_q == DRIVE && !w_blink_off && !w_lzb_off) begin
         an_d = ~(ONE_DIG << idx_q);
      end
   end

   always_ff @(posedge mclk) begin
      if (clr) begin
         an_q          <= '1;
         seg_q         <= SEG_OFF;
         dp_n_q        <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_n_q        <= dp_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp_n        = dp_n_q;
   assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module      : tb_seg7_scan_ctrl
// Description : Self-checking bench for seg7_scan_ctrl (NDIG = 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;

   localparam int NDIG = 8;
`ifdef SEG7_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        mclk = 1'b0;
   logic        clr = 1'b1;
   logic        scan_clk = 1'b0;
   logic        blink_clk = 1'b1;
   logic [31:0] data = 32'h1234_5678;
   logic [7:0]  dp = 8'h00;
   logic [7:0]  blink_mask = 8'h00;
   logic [7:0]  an;
   logic [6:0]  seg;
   logic        dp_n;
   logic        frame_start;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] HEX [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   seg7_scan_ctrl #(.NDIG(NDIG)) dut (
      .mclk        (mclk),
      .clr         (clr),
      .scan_clk    (scan_clk),
      .blink_clk   (blink_clk),
      .data        (data),
      .dp          (dp),
      .blink_mask  (blink_mask),
      .an          (an),
      .seg         (seg),
      .dp_n        (dp_n),
      .frame_start (frame_start)
   );

   always #5 mclk = ~mclk;

   // Behavioural model: what the display must show, derived from the rules
   int          m_scan_hist [3];
   int          m_blink_hist [2];
   bit          m_driving;
   int          m_digit;
   bit          m_after_frame_gap;
   logic [31:0] m_data;
   logic [7:0]  m_dp;
   logic [7:0]  m_bm;
   logic [7:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dpn;
   logic        e_fs;

   task automatic model_step();
      int  msd;
      bit  shown;
      bit  tick;
      if (clr) begin
         m_driving = 1'b0;
         m_digit = 0;
         m_after_frame_gap = 1'b0;
         m_data = '0;
         m_dp = '0;
         m_bm = '0;
         e_an = 8'hFF;
         e_seg = 7'h7F;
         e_dpn = 1'b1;
         e_fs = 1'b0;
         m_scan_hist = '{0, 0, 0};
         m_blink_hist = '{0, 0};
      end else begin
         msd = 0;
         for (int k = 1; k < NDIG; k++)
            if (m_data[4*k +: 4] != 4'h0) msd = k;
         shown = m_driving && !(m_blink_hist[1] == 0 && m_bm[m_digit])
                 && !(LZB && m_digit > msd);
         e_an  = shown ? (8'hFF ^ (8'h01 << m_digit)) : 8'hFF;
         e_seg = HEX[m_data[4*m_digit +: 4]];
         e_dpn = !m_dp[m_digit];
         e_fs  = m_driving && m_digit == 0 && m_after_frame_gap;
         tick  = (m_scan_hist[1] == 1) && (m_scan_hist[2] == 0);
         m_after_frame_gap = !m_driving && m_digit == 0;
         if (!m_driving) begin
            if (m_digit == 0) begin
               m_data = data;
               m_dp   = dp;
               m_bm   = blink_mask;
            end
            m_driving = 1'b1;
         end else if (tick) begin
            m_digit   = (m_digit + 1) % NDIG;
            m_driving = 1'b0;
         end
         m_scan_hist[2]  = m_scan_hist[1];
         m_scan_hist[1]  = m_scan_hist[0];
         m_scan_hist[0]  = int'(scan_clk);
         m_blink_hist[1] = m_blink_hist[0];
         m_blink_hist[0] = int'(blink_clk);
      end
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Literal expectation: pins both the DUT and the model to a hand value.
   task automatic lit(string nm, logic [31:0] act, logic [31:0] mdl, logic [31:0] exp);
      chk(nm, act, exp);
      chk({nm, "_model"}, mdl, exp);
   endtask

   task automatic cycle(int n);
      repeat (n) begin
         @(posedge mclk);
         model_step();
         #1;
         chk("an", {24'h0, an}, {24'h0, e_an});
         chk("seg", {25'h0, seg}, {25'h0, e_seg});
         chk("dp_n", {31'h0, dp_n}, {31'h0, e_dpn});
         chk("frame_start", {31'h0, frame_start}, {31'h0, e_fs});
      end
   endtask

   task automatic scan_edge(string nm, logic [7:0] ea, logic [6:0] es,
                            logic ed, logic ef, bit do_lit);
      scan_clk = 1'b1;
      cycle(4);
      if (do_lit) lit({nm, "_gap_an"}, {24'h0, an}, {24'h0, e_an}, 32'hFF);
      scan_clk = 1'b0;
      cycle(1);
      if (do_lit) begin
         lit({nm, "_an"}, {24'h0, an}, {24'h0, e_an}, {24'h0, ea});
         lit({nm, "_seg"}, {25'h0, seg}, {25'h0, e_seg}, {25'h0, es});
         lit({nm, "_dp_n"}, {31'h0, dp_n}, {31'h0, e_dpn}, {31'h0, ed});
         lit({nm, "_fs"}, {31'h0, frame_start}, {31'h0, e_fs}, {31'h0, ef});
      end
      cycle(3);
   endtask

   logic [7:0] scan_an  [8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
   logic [6:0] scan_seg [8] = '{7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
                                7'b0000110, 7'b0010010, 7'b1001111, 7'b0000000};

   initial begin
      // Reset
      cycle(2);
      lit("reset_an", {24'h0, an}, {24'h0, e_an}, 32'hFF);
      lit("reset_seg", {25'h0, seg}, {25'h0, e_seg}, 32'h7F);
      lit("reset_dp_n", {31'h0, dp_n}, {31'h0, e_dpn}, 32'h1);
      lit("reset_fs", {31'h0, frame_start}, {31'h0, e_fs}, 32'h0);
      clr = 1'b0;
      cycle(1);
      lit("post_reset_blank_an", {24'h0, an}, {24'h0, e_an}, 32'hFF);
      cycle(1);
      lit("post_reset_an", {24'h0, an}, {24'h0, e_an}, 32'hFE);
      lit("post_reset_seg", {25'h0, seg}, {25'h0, e_seg}, 32'h00);
      lit("post_reset_fs", {31'h0, frame_start}, {31'h0, e_fs}, 32'h1);
      cycle(1);
      lit("post_reset_fs_drop", {31'h0, frame_start}, {31'h0, e_fs}, 32'h0);
      cycle(4);

      // Full scan of one frame
      for (int i = 0; i < 8; i++)
         scan_edge($sformatf("scan%0d", i), scan_an[i], scan_seg[i], 1'b1, (i == 7), 1'b1);

      // Tear-free: change data mid-frame at digit 3
      for (int i = 0; i < 3; i++)
         scan_edge($sformatf("tear_pre%0d", i), scan_an[i], scan_seg[i], 1'b1, 1'b0, 1'b1);
      data = 32'hDEAD_BEEF;
      for (int i = 3; i < 7; i++)
         scan_edge($sformatf("tear_hold%0d", i), scan_an[i], scan_seg[i], 1'b1, 1'b0, 1'b1);
      scan_edge("tear_wrap", 8'hFE, 7'b0111000, 1'b1, 1'b1, 1'b1);

      // Blink and decimal point
      blink_mask = 8'h01;
      dp         = 8'h02;
      blink_clk  = 1'b0;
      for (int i = 0; i < 7; i++)
         scan_edge("blink_fill", 8'h00, 7'h00, 1'b0, 1'b0, 1'b0);
      scan_edge("blink_off", 8'hFF, 7'b0111000, 1'b1, 1'b1, 1'b1);
      blink_clk = 1'b1;
      cycle(3);
      lit("blink_on_an", {24'h0, an}, {24'h0, e_an}, 32'hFE);
      scan_edge("dp_digit1", 8'hFD, 7'b0110000, 1'b0, 1'b0, 1'b1);

      // Leading-zero handling
      blink_mask = 8'h00;
      dp         = 8'h00;
      data       = 32'h0000_00A5;
      for (int i = 0; i < 6; i++)
         scan_edge("lzb_fill", 8'h00, 7'h00, 1'b0, 1'b0, 1'b0);
      scan_edge("lzb_d0", 8'hFE, 7'b0100100, 1'b1, 1'b1, 1'b1);
      scan_edge("lzb_d1", 8'hFD, 7'b0001000, 1'b1, 1'b0, 1'b1);
      for (int k = 2; k < 8; k++)
         scan_edge($sformatf("lzb_d%0d", k), LZB ? 8'hFF : (8'hFF ^ (8'h01 << k)),
                   7'b0000001, 1'b1, 1'b0, 1'b1);
      data = 32'h0;
      scan_edge("zero_d0", 8'hFE, 7'b0000001, 1'b1, 1'b1, 1'b1);
      scan_edge("zero_d1", LZB ? 8'hFF : 8'hFD, 7'b0000001, 1'b1, 1'b0, 1'b1);

      // Mid-frame reset at digit 5
      data = 32'h1234_5678;
      for (int i = 0; i < 4; i++)
         scan_edge("mid_fill", 8'h00, 7'h00, 1'b0, 1'b0, 1'b0);
      clr = 1'b1;
      cycle(1);
      lit("mid_reset_an", {24'h0, an}, {24'h0, e_an}, 32'hFF);
      lit("mid_reset_seg", {25'h0, seg}, {25'h0, e_seg}, 32'h7F);
      lit("mid_reset_dp_n", {31'h0, dp_n}, {31'h0, e_dpn}, 32'h1);
      lit("mid_reset_fs", {31'h0, frame_start}, {31'h0, e_fs}, 32'h0);
      clr = 1'b0;
      cycle(1);
      lit("mid_restart_blank", {24'h0, an}, {24'h0, e_an}, 32'hFF);
      cycle(1);
      lit("mid_restart_an", {24'h0, an}, {24'h0, e_an}, 32'hFE);
      lit("mid_restart_seg", {25'h0, seg}, {25'h0, e_seg}, 32'h00);
      lit("mid_restart_fs", {31'h0, frame_start}, {31'h0, e_fs}, 32'h1);
      cycle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed 7-segment display driver for register-file read data on the board's 8-digit common-anode display.
- Sits directly downstream of the clock divider and consumes its slow square waves: the ~190 Hz scan output paces digit scanning, and the ~1.4 Hz output paces blinking.
- Both slow inputs are sampled in the mclk domain; no derived clocks are used inside the block.

Parameters:
- NDIG, 8, number of digits scanned; legal range 2..8. Data width is 4*NDIG.

Ports:
- mclk  in  1  system clock; the only clock.
- clr  in  1  reset: synchronous, active-high.
- scan_clk  in  1  slow scan square wave from the divider (nominal 190 Hz).
- blink_clk  in  1  slow blink square wave from the divider (nominal 1.4 Hz).
- data  in  4*NDIG  value to show; nibble k (data[4k+3:4k]) goes to digit k; digit 0 is rightmost.
- dp  in  NDIG  decimal point request per digit; 1 = lit.
- blink_mask  in  NDIG  1 = digit blinks.
- an  out  NDIG  anode enables, active-low, one-hot-low.
- seg  out  7  segments, active-low; seg[6]=a ... seg[0]=g.
- dp_n  out  1  decimal point, active-low.
- frame_start  out  1  one-cycle pulse when digit 0 of a new frame is first driven.

Behaviour:
- Clock and reset: one clock, mclk; reset clr is synchronous and active-high.
- Synchronisers:
  - scan_clk and blink_clk each pass through 2 flops, plus a third flop for scan_clk edge detect.
  - scan_tick = synced rising edge of scan_clk; it is a 1-cycle pulse 3 mclk cycles after the input edge.
  - blink_on = synced blink_clk level.
- Digit index idx, width clog2(NDIG):
  - Advances on scan_tick.
  - Wraps NDIG-1 -> 0.
- State machine, 2 states:
  - BLANK: an = all ones. Lasts exactly 1 cycle, then goes to DRIVE. If idx == 0 in BLANK, the shadow registers (data_s, dp_s, blink_s) load from data, dp and blink_mask.
  - DRIVE: holds until scan_tick. On scan_tick, idx advances and the state goes to BLANK (anti-ghosting gap).
  - Synced rising edges are at least 2 cycles apart, so a scan_tick can never land in BLANK.
- Outputs, all registered and updated on the cycle after the state/idx change:
  - In DRIVE: an[idx] = 0, all other anodes = 1.
  - seg = hex pattern of data_s nibble idx.
  - dp_n = ~dp_s[idx].
  - Blink: when blink_on == 0 and blink_s[idx] == 1, an = all ones. seg and dp_n are unaffected.
  - frame_start = 1 for exactly the first cycle in which the idx 0 anode is driven (or would be, if suppressed by blink or blanking).
- Tear-free display: the shadow registers change only at frame start, so a mid-frame change to data never mixes two values within one frame.
- Hex decode, seg[6:0] active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Reset values:
  - idx = 0, state = BLANK.
  - an = all ones, seg = 7'h7F, dp_n = 1, frame_start = 0.
  - Shadow registers = 0, sync flops = 0.
  - After clr falls: cycle 1 is BLANK (shadow load), cycle 2 drives digit 0 with frame_start = 1.
- Reset mid-operation: same values on the next edge; the scan restarts at digit 0.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- With the macro: every digit k above the most significant nonzero nibble of data_s keeps an = all ones during its slot. Digit 0 is always shown, so data_s = 0 displays a single "0". The digit timing slot is preserved.
- Without the macro: all NDIG digits are shown.

Decomposition:
- Package seg7_pkg: state enum {BLANK, DRIVE}, 16-entry hex-to-segment constant table, SEG_OFF = 7'h7F.
- Sub-module seg7_hex_decode: combinational 4-bit nibble -> 7-bit pattern, using the package table.
- Synchronisers, FSM and shadow registers stay in the top module.

Test Plan:
- Reset: hold clr 2 cycles with data = 32'h1234_5678 -> an = 8'hFF, seg = 7'h7F, dp_n = 1. After release: 1 BLANK cycle, then an = 8'hFE, seg = 7'h00 ("8"), frame_start high for 1 cycle.
- Scan: 8 scan_clk rising edges -> an goes FE, FD, FB, F7, EF, DF, BF, 7F, FE, with one FF cycle before each. seg shows 8, 7, 6, 5, 4, 3, 2, 1. Each advance occurs 3-4 cycles after its edge.
- Tear-free: while idx = 3, set data = 32'hDEAD_BEEF -> digits 4..7 still show 4, 3, 2, 1. After the wrap, digit 0 shows F (7'b0111000) and frame_start pulses.
- Blink and dp: blink_mask = 8'h01, dp = 8'h02.
  - With blink_clk low: the digit 0 slot has an = 8'hFF.
  - With blink_clk high: an = 8'hFE.
  - In the digit 1 slot: dp_n = 0.
- LZB: data = 32'h0000_00A5.
  - With SEG7_LZB_EN: slots 2..7 have an = 8'hFF.
  - Without the macro: those slots show seg = 7'b0000001.
  - data = 0 with the macro: only digit 0 is lit, showing "0".
- Mid-frame reset: assert clr for 1 cycle at idx = 5 -> next edge gives reset values, and the scan restarts at digit 0 with a fresh shadow load.
